// File: rtl/delay_line_ctrl.sv
// Single-tap echo controller around an external dual-port delay memory.
// Optional DELAY_FEEDBACK_EN: write the wet sample back (regenerating echo) instead of the dry one.
module delay_line_ctrl #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [ADDR_WIDTH-1:0] DELAY,
  input  logic [7:0]            GAIN,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR1,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR2,
  output logic [DATA_WIDTH-1:0] MEM_DI,
  input  logic [DATA_WIDTH-1:0] MEM_DO2
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int PW  = DATA_WIDTH + 9;
  localparam logic [AW1-1:0] SIZE_W = AW1'(SIZE);
  localparam logic [AW1-1:0] D_MAX  = AW1'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RD, MIX, OUT} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [AW1-1:0]          fill, d_q;
  logic [DATA_WIDTH-1:0]   dry_q;
  logic [7:0]              gain_q;

  logic [AW1-1:0]          delay_ext, d_eff, wp_ext, rd_addr;
  logic [DATA_WIDTH-1:0]   delayed, mix;
  logic signed [PW-1:0]    dl_ext, g_ext, prod, scaled, sum;

  // Clamp the requested delay and form the circular read address.
  always_comb begin
    delay_ext = {1'b0, DELAY};
    if (delay_ext == '0)          d_eff = AW1'(1);
    else if (delay_ext >= SIZE_W) d_eff = D_MAX;
    else                          d_eff = delay_ext;
    wp_ext  = {1'b0, wr_ptr};
    rd_addr = (wp_ext >= d_eff) ? wp_ext - d_eff : wp_ext + SIZE_W - d_eff;
  end

  // Words older than the fill count are stale (e.g. from before a reset).
  always_comb begin
    delayed = (d_q > fill) ? '0 : MEM_DO2;
    dl_ext  = {{9{delayed[DATA_WIDTH-1]}}, delayed};
    g_ext   = {{(PW-8){1'b0}}, gain_q};
    prod    = dl_ext * g_ext;
    scaled  = prod >>> 8;
    sum     = {{9{dry_q[DATA_WIDTH-1]}}, dry_q} + scaled;
    if (sum > SAT_MAX)      mix = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum < SAT_MIN) mix = SAT_MIN[DATA_WIDTH-1:0];
    else                    mix = sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      MEM_WE    <= 1'b0;
      MEM_ADDR1 <= '0;
      MEM_ADDR2 <= '0;
      MEM_DI    <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      d_q       <= '0;
      dry_q     <= '0;
      gain_q    <= '0;
    end else begin
      // The write lands on the cycle MEM_WE is high; pointer and fill follow it.
      if (MEM_WE) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        if (fill != SIZE_W) fill <= fill + AW1'(1);
      end
      case (state)
        IDLE: begin
          IN_READY <= 1'b1;
          if (IN_VALID && IN_READY) begin
            dry_q     <= IN_DATA;
            gain_q    <= GAIN;
            d_q       <= d_eff;
            MEM_ADDR2 <= rd_addr[ADDR_WIDTH-1:0];
            IN_READY  <= 1'b0;
            state     <= RD;
          end
        end
        RD: state <= MIX;
        MIX: begin
          OUT_DATA  <= mix;
          OUT_VALID <= 1'b1;
          MEM_WE    <= 1'b1;
          MEM_ADDR1 <= wr_ptr;
`ifdef DELAY_FEEDBACK_EN
          MEM_DI    <= mix;
`else
          MEM_DI    <= dry_q;
`endif
          state     <= OUT;
        end
        OUT: begin
          MEM_WE <= 1'b0;
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
